// File: rtl/decode_pkg.sv
// Shared encodings and the decoded-entry record for the fetch/decode queue.
// Combinational helpers only; no state lives here.
// Unit/op/imm codes are consumed by the issue stage as-is.
package decode_pkg;

  // Execution unit
  localparam logic [1:0] UNIT_ALU = 2'b00;
  localparam logic [1:0] UNIT_BRU = 2'b01;
  localparam logic [1:0] UNIT_LSU = 2'b10;
  localparam logic [1:0] UNIT_MUL = 2'b11;

  // Immediate format
  localparam logic [3:0] IMM_NONE = 4'd0;
  localparam logic [3:0] IMM_I    = 4'd1;
  localparam logic [3:0] IMM_S    = 4'd2;
  localparam logic [3:0] IMM_B    = 4'd3;
  localparam logic [3:0] IMM_U    = 4'd4;
  localparam logic [3:0] IMM_J    = 4'd5;

  // ALU operations; BRU uses 0=JAL, 1=JALR, {1,funct3}=branch;
  // LSU uses {is_store, funct3}; MUL uses {0, funct3}
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_LUI   = 4'd10;
  localparam logic [3:0] OP_AUIPC = 4'd11;
  localparam logic [3:0] OP_NOP   = 4'd12;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        rd_valid;
    logic        rs1_valid;
    logic        rs2_valid;
    logic        is_wfi;
    logic [3:0]  imm;
    logic [1:0]  unit;
    logic [3:0]  op;
    logic        illegal;
  } dec_entry_t;

  // Map funct3 (plus the funct7[5] alternate bit) of OP/OP-IMM to an ALU op
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? OP_SUB : OP_ADD;
      3'd1:    return OP_SLL;
      3'd2:    return OP_SLT;
      3'd3:    return OP_SLTU;
      3'd4:    return OP_XOR;
      3'd5:    return alt ? OP_SRA : OP_SRL;
      3'd6:    return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_pla.sv
// Single-word RV32I(+M) decoder: raw word + PC in, decoded entry out.
// Latency: purely combinational.
// Backpressure: none; unrecognised words come out flagged illegal with all decode fields zero.
module decode_pla
  import decode_pkg::*;
#(
  parameter int M_EXT = 0
) (
  input  logic [31:0] i_insn,
  input  logic [31:0] i_pc,
  output dec_entry_t  o_entry
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_legal;
  logic       w_rd, w_rs1, w_rs2, w_wfi;
  logic [3:0] w_imm;
  logic [1:0] w_unit;
  logic [3:0] w_op;

  assign w_opc = i_insn[6:0];
  assign w_f3  = i_insn[14:12];
  assign w_f7  = i_insn[31:25];

  // Opcode classification; any unmatched encoding leaves w_legal low
  always_comb begin
    w_legal = 1'b0;
    w_rd    = 1'b0;
    w_rs1   = 1'b0;
    w_rs2   = 1'b0;
    w_wfi   = 1'b0;
    w_imm   = IMM_NONE;
    w_unit  = UNIT_ALU;
    w_op    = OP_NOP;
    case (w_opc)
      7'b0110111: begin w_legal = 1'b1; w_rd = 1'b1; w_imm = IMM_U; w_op = OP_LUI; end
      7'b0010111: begin w_legal = 1'b1; w_rd = 1'b1; w_imm = IMM_U; w_op = OP_AUIPC; end
      7'b1101111: begin
        w_legal = 1'b1; w_rd = 1'b1; w_imm = IMM_J; w_unit = UNIT_BRU; w_op = 4'd0;
      end
      7'b1100111: begin
        w_legal = (w_f3 == 3'd0);
        w_rd = 1'b1; w_rs1 = 1'b1; w_imm = IMM_I; w_unit = UNIT_BRU; w_op = 4'd1;
      end
      7'b1100011: begin
        w_legal = (w_f3 != 3'd2) && (w_f3 != 3'd3);
        w_rs1 = 1'b1; w_rs2 = 1'b1; w_imm = IMM_B; w_unit = UNIT_BRU; w_op = {1'b1, w_f3};
      end
      7'b0000011: begin
        w_legal = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
        w_rd = 1'b1; w_rs1 = 1'b1; w_imm = IMM_I; w_unit = UNIT_LSU; w_op = {1'b0, w_f3};
      end
      7'b0100011: begin
        w_legal = (w_f3 <= 3'd2);
        w_rs1 = 1'b1; w_rs2 = 1'b1; w_imm = IMM_S; w_unit = UNIT_LSU; w_op = {1'b1, w_f3};
      end
      7'b0010011: begin
        // Shift-immediates carry funct7 in the upper bits; only SRAI may set bit 30
        if (w_f3 == 3'd1)      w_legal = (w_f7 == 7'b0000000);
        else if (w_f3 == 3'd5) w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
        else                   w_legal = 1'b1;
        w_rd = 1'b1; w_rs1 = 1'b1; w_imm = IMM_I;
        w_op = alu_op(w_f3, (w_f3 == 3'd5) && w_f7[5]);
      end
      7'b0110011: begin
        w_rd = 1'b1; w_rs1 = 1'b1; w_rs2 = 1'b1;
        if (w_f7 == 7'b0000000) begin
          w_legal = 1'b1; w_op = alu_op(w_f3, 1'b0);
        end else if ((w_f7 == 7'b0100000) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))) begin
          w_legal = 1'b1; w_op = alu_op(w_f3, 1'b1);
        end else if ((w_f7 == 7'b0000001) && (M_EXT != 0)) begin
          w_legal = 1'b1; w_unit = UNIT_MUL; w_op = {1'b0, w_f3};
        end
      end
      7'b0001111: w_legal = (w_f3 == 3'd0);
      7'b1110011: begin
        // WFI is the only SYSTEM word this core executes
        w_legal = (i_insn == 32'h1050_0073);
        w_wfi   = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal words keep only pc/insn so downstream can raise the trap
  always_comb begin
    o_entry           = '0;
    o_entry.pc        = i_pc;
    o_entry.insn      = i_insn;
    o_entry.illegal   = ~w_legal;
    if (w_legal) begin
      o_entry.rd_valid  = w_rd;
      o_entry.rs1_valid = w_rs1;
      o_entry.rs2_valid = w_rs2;
      o_entry.is_wfi    = w_wfi;
      o_entry.imm       = w_imm;
      o_entry.unit      = w_unit;
      o_entry.op        = w_op;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Decodes each present slot of a fetch bundle and buffers the entries in order.
// Latency: an entry accepted at edge N is at the head in cycle N+1 when the buffer was empty.
// Backpressure: in_ready is high only while a whole bundle fits, taken from registered count.
module decode_queue
  import decode_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 4,
  parameter int M_EXT   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*FETCH_W-1:0]  in_insn,
  input  logic [FETCH_W-1:0]     in_mask,
  input  logic [31:0]            in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_insn,
  output logic                   out_rd_valid,
  output logic                   out_rs1_valid,
  output logic                   out_rs2_valid,
  output logic                   out_is_wfi,
  output logic                   out_illegal,
  output logic [3:0]             out_imm,
  output logic [1:0]             out_unit,
  output logic [3:0]             out_op
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  if ((FETCH_W < 1) || (FETCH_W > 4) || (DEPTH < FETCH_W) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_cfg
    $error("decode_queue: FETCH_W must be 1..4 and DEPTH a power of two >= FETCH_W");
  end

  dec_entry_t       r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  dec_entry_t       w_dec [FETCH_W];
  logic [PW-1:0]    w_idx [FETCH_W];
  logic [CW-1:0]    w_push_cnt;
  logic [CW-1:0]    w_push_n;
  logic             w_fire_in;
  logic             w_fire_out;
  dec_entry_t       w_head;

  // Pointer advance modulo DEPTH; n never exceeds DEPTH so one subtract suffices
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
    logic [CW:0] s;
    s = (CW+1)'(p) + (CW+1)'(n);
    if (s >= (CW+1)'(DEPTH)) s = s - (CW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  for (genvar g = 0; g < FETCH_W; g++) begin : g_pla
    decode_pla #(.M_EXT(M_EXT)) u_pla (
      .i_insn  (in_insn[32*g +: 32]),
      .i_pc    (in_pc + 32'(4 * g)),
      .o_entry (w_dec[g])
    );
  end

  assign in_ready   = (r_count <= CW'(DEPTH - FETCH_W));
  assign out_valid  = (r_count != '0);
  assign w_fire_in  = in_valid & in_ready & ~flush & ~reset;
  assign w_fire_out = out_valid & out_ready;
  assign w_push_n   = w_fire_in ? w_push_cnt : '0;

  // Compact present slots: each gets the next free entry after the lower present slots
  always_comb begin
    w_push_cnt = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_idx[i] = ptr_add(r_wr_ptr, w_push_cnt);
      if (in_mask[i]) w_push_cnt = w_push_cnt + CW'(1);
    end
  end

  // Occupancy and pointers; reset and flush both empty the buffer and win over traffic
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fire_in)  r_wr_ptr <= ptr_add(r_wr_ptr, w_push_cnt);
      if (w_fire_out) r_rd_ptr <= ptr_add(r_rd_ptr, CW'(1));
      r_count <= r_count + w_push_n - CW'(w_fire_out);
    end
  end

  // Entry storage is data-only and deliberately not reset
  always_ff @(posedge clk) begin
    if (w_fire_in) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (in_mask[i]) r_mem[w_idx[i]] <= w_dec[i];
      end
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign out_pc        = w_head.pc;
  assign out_insn      = w_head.insn;
  assign out_rd_valid  = w_head.rd_valid;
  assign out_rs1_valid = w_head.rs1_valid;
  assign out_rs2_valid = w_head.rs2_valid;
  assign out_is_wfi    = w_head.is_wfi;
  assign out_illegal   = w_head.illegal;
  assign out_imm       = w_head.imm;
  assign out_unit      = w_head.unit;
  assign out_op        = w_head.op;

endmodule

// File: tb/tb_decode_queue.sv
// Directed and scoreboard bench for decode_queue (FETCH_W=2, DEPTH=4).
// A second instance with M_EXT=1 shares all inputs and is checked for RV32M decode.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [63:0] in_insn;
  logic [1:0]  in_mask;
  logic [31:0] in_pc;

  logic        in_ready, out_valid, out_rd_valid, out_rs1_valid, out_rs2_valid, out_is_wfi, out_illegal;
  logic [31:0] out_pc, out_insn;
  logic [3:0]  out_imm, out_op;
  logic [1:0]  out_unit;

  logic        m_in_ready, m_out_valid, m_rd, m_rs1, m_rs2, m_wfi, m_ill;
  logic [31:0] m_pc, m_insn;
  logic [3:0]  m_imm, m_op;
  logic [1:0]  m_unit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_queue #(.FETCH_W(2), .DEPTH(4), .M_EXT(0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_mask(in_mask), .in_pc(in_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_insn(out_insn), .out_rd_valid(out_rd_valid),
    .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid), .out_is_wfi(out_is_wfi),
    .out_illegal(out_illegal), .out_imm(out_imm), .out_unit(out_unit), .out_op(out_op)
  );

  decode_queue #(.FETCH_W(2), .DEPTH(4), .M_EXT(1)) dut_m (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_insn(in_insn), .in_mask(in_mask), .in_pc(in_pc), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_pc(m_pc), .out_insn(m_insn), .out_rd_valid(m_rd),
    .out_rs1_valid(m_rs1), .out_rs2_valid(m_rs2), .out_is_wfi(m_wfi),
    .out_illegal(m_ill), .out_imm(m_imm), .out_unit(m_unit), .out_op(m_op)
  );

  // {rd, rs1, rs2, wfi, imm[3:0], unit[1:0], op[3:0], illegal}
  function automatic logic [14:0] pk(input logic rd, rs1, rs2, wfi, input logic [3:0] imm,
                                     input logic [1:0] unit, input logic [3:0] op, input logic ill);
    return {rd, rs1, rs2, wfi, imm, unit, op, ill};
  endfunction

  wire [14:0] dec0 = {out_rd_valid, out_rs1_valid, out_rs2_valid, out_is_wfi, out_imm, out_unit, out_op, out_illegal};
  wire [14:0] dec1 = {m_rd, m_rs1, m_rs2, m_wfi, m_imm, m_unit, m_op, m_ill};

  typedef struct {
    logic [31:0] insn;
    logic [14:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_mask = 2'b00;
  endtask

  vec_t        vecs [14];
  logic [63:0] q [$];
  logic [14:0] illegal_only;

  initial begin
    illegal_only = pk(0,0,0,0,4'd0,2'd0,4'd0,1);
    vecs[0]  = '{32'h0020_8033, pk(1,1,1,0,4'd0,2'd0,4'd0,0)};   // add
    vecs[1]  = '{32'h4020_8033, pk(1,1,1,0,4'd0,2'd0,4'd1,0)};   // sub
    vecs[2]  = '{32'h0050_0093, pk(1,1,0,0,4'd1,2'd0,4'd0,0)};   // addi
    vecs[3]  = '{32'h1234_50B7, pk(1,0,0,0,4'd4,2'd0,4'd10,0)};  // lui
    vecs[4]  = '{32'h0000_006F, pk(1,0,0,0,4'd5,2'd1,4'd0,0)};   // jal
    vecs[5]  = '{32'h0020_8463, pk(0,1,1,0,4'd3,2'd1,4'd8,0)};   // beq
    vecs[6]  = '{32'h0000_A083, pk(1,1,0,0,4'd1,2'd2,4'd2,0)};   // lw
    vecs[7]  = '{32'h0020_A023, pk(0,1,1,0,4'd2,2'd2,4'd10,0)};  // sw
    vecs[8]  = '{32'h4010_D093, pk(1,1,0,0,4'd1,2'd0,4'd7,0)};   // srai
    vecs[9]  = '{32'h0000_0073, illegal_only};                   // ecall
    vecs[10] = '{32'h1050_0073, pk(0,0,0,1,4'd0,2'd0,4'd12,0)};  // wfi
    vecs[11] = '{32'h0220_81B3, illegal_only};                   // mul, M_EXT=0
    vecs[12] = '{32'h0000_0000, illegal_only};                   // all zero
    vecs[13] = '{32'h0FF0_000F, pk(0,0,0,0,4'd0,2'd0,4'd12,0)};  // fence

    idle_inputs();
    in_insn = '0; in_pc = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready",  {63'd0, in_ready},  64'd1);

    // Two-slot bundle: add then wfi
    in_valid = 1'b1; in_mask = 2'b11; in_pc = 32'h100;
    in_insn = {32'h1050_0073, 32'h0020_8033};
    tick();
    in_valid = 1'b0;
    chk("b_valid0", {63'd0, out_valid}, 64'd1);
    chk("b_pc0",    {32'd0, out_pc}, 64'h100);
    chk("b_dec0",   {49'd0, dec0}, {49'd0, pk(1,1,1,0,4'd0,2'd0,4'd0,0)});
    out_ready = 1'b1;
    tick();
    chk("b_pc1",    {32'd0, out_pc}, 64'h104);
    chk("b_dec1",   {49'd0, dec0}, {49'd0, pk(0,0,0,1,4'd0,2'd0,4'd12,0)});
    tick();
    out_ready = 1'b0;
    chk("b_empty",  {63'd0, out_valid}, 64'd0);

    // Fill to capacity with out_ready low
    in_valid = 1'b1; in_mask = 2'b11;
    for (int k = 0; k < 3; k++) begin
      in_pc = 32'h200 + 32'(8 * k);
      chk($sformatf("fill_rdy%0d", k), {63'd0, in_ready}, (k < 2) ? 64'd1 : 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_head",     {32'd0, out_pc}, 64'h200);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("free1_in_ready", {63'd0, in_ready}, 64'd0);
    chk("free1_head",     {32'd0, out_pc}, 64'h204);
    out_ready = 1'b1;
    tick();
    chk("free2_in_ready", {63'd0, in_ready}, 64'd1);
    chk("free2_head",     {32'd0, out_pc}, 64'h208);
    tick();
    chk("drain_head",     {32'd0, out_pc}, 64'h20C);
    tick();
    out_ready = 1'b0;
    chk("drain_empty",    {63'd0, out_valid}, 64'd0);

    // Only slot 1 present
    in_valid = 1'b1; in_mask = 2'b10; in_pc = 32'h300;
    in_insn = {32'h0020_8033, 32'h0000_0000};
    tick();
    in_valid = 1'b0;
    chk("m10_valid", {63'd0, out_valid}, 64'd1);
    chk("m10_pc",    {32'd0, out_pc}, 64'h304);
    chk("m10_insn",  {32'd0, out_insn}, 64'h0020_8033);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("m10_single", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1; in_mask = 2'b00;
    chk("m00_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("m00_empty", {63'd0, out_valid}, 64'd0);
    chk("m00_ready_after", {63'd0, in_ready}, 64'd1);

    // Flush a full buffer while offering and popping
    in_valid = 1'b1; in_mask = 2'b11; in_pc = 32'h500; tick();
    in_pc = 32'h508; tick();
    chk("pre_flush_full", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    idle_inputs();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_mask = 2'b01; in_pc = 32'h600;
    tick();
    in_valid = 1'b0;
    chk("post_flush_pc", {32'd0, out_pc}, 64'h600);
    // Flush with room available must still drop the offered bundle
    flush = 1'b1; in_valid = 1'b1; in_mask = 2'b11; in_pc = 32'h700; out_ready = 1'b1;
    tick();
    idle_inputs();
    chk("flush_drops_push", {63'd0, out_valid}, 64'd0);

    // Reset wins over push, pop and flush together
    in_valid = 1'b1; in_mask = 2'b11; in_pc = 32'h800; tick();
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; idle_inputs();
    chk("rst_pri_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_pri_ready", {63'd0, in_ready}, 64'd1);

    // Decode table, one slot at a time
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_mask = 2'b01; in_pc = 32'h400 + 32'(4 * i);
      in_insn = {32'h0, vecs[i].insn};
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_dec", i), {49'd0, dec0}, {49'd0, vecs[i].exp});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // RV32M only with the extension enabled
    in_valid = 1'b1; in_mask = 2'b01; in_pc = 32'h900;
    in_insn = {32'h0, 32'h0220_81B3};
    tick();
    in_valid = 1'b0;
    chk("mul_m0", {49'd0, dec0}, {49'd0, illegal_only});
    chk("mul_m1", {49'd0, dec1}, {49'd0, pk(1,1,1,0,4'd0,2'd3,4'd0,0)});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Random push/pop against a scoreboard queue
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic acc, pop;
      in_valid  = 1'($urandom_range(0, 1));
      in_mask   = 2'($urandom_range(0, 3));
      in_pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      in_insn   = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      #0;
      chk("rnd_valid", {63'd0, out_valid}, (q.size() != 0) ? 64'd1 : 64'd0);
      chk("rnd_ready", {63'd0, in_ready}, ((4 - q.size()) >= 2) ? 64'd1 : 64'd0);
      if (q.size() != 0) chk("rnd_head", {out_pc, out_insn}, q[0]);
      pop = (q.size() != 0) && out_ready;
      acc = in_valid && ((4 - q.size()) >= 2);
      if (pop) void'(q.pop_front());
      if (acc) begin
        for (int s = 0; s < 2; s++) begin
          if (in_mask[s]) q.push_back({in_pc + 32'(4 * s), in_insn[32*s +: 32]});
        end
      end
      tick();
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter FETCH_W, default 2: 32-bit instruction slots per fetch bundle; legal range 1..4.
REQ-002 Parameter DEPTH, default 4: decoded-entry buffer depth; power of two and >= FETCH_W.
REQ-003 Parameter M_EXT, default 0: 1 = decode RV32M multiply/divide, 0 = treat as illegal.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  discard all buffered entries and the bundle offered this cycle.
REQ-007 in_valid  in  1  fetch bundle offered.
REQ-008 in_ready  out  1  bundle accepted when in_valid & in_ready.
REQ-009 in_insn  in  32*FETCH_W  slot i at bits [32i+31:32i].
REQ-010 in_mask  in  FETCH_W  slot i present when bit i set.
REQ-011 in_pc  in  32  PC of slot 0; slot i PC = in_pc + 4*i, mod 2^32.
REQ-012 out_valid  out  1  head entry present.
REQ-013 out_ready  in  1  head consumed when out_valid & out_ready.
REQ-014 out_pc, out_insn  out  32 each  PC and raw word of head entry.
REQ-015 out_rd_valid, out_rs1_valid, out_rs2_valid, out_is_wfi, out_illegal  out  1 each  decoded flags of head.
REQ-016 out_imm 4, out_unit 2, out_op 4  out  decoded immediate format, execution unit, operation.

Function
REQ-017 Each present slot of an accepted bundle SHALL be decoded combinationally and written, in ascending slot order, into consecutive buffer entries in the same edge.
REQ-018 Absent slots SHALL occupy no entry; an all-zero in_mask bundle SHALL be accepted and write nothing.
REQ-019 in_ready SHALL equal (DEPTH - count) >= FETCH_W, from registered count only; no combinational path from out_ready or in_valid.
REQ-020 Latency: a slot accepted at edge N SHALL appear at head no earlier than cycle N+1; empty-buffer case exactly N+1.
REQ-021 out_valid SHALL equal count != 0; head fields SHALL come directly from buffer storage.
REQ-022 Push and pop in the same cycle SHALL both occur; count += pushed - popped.
REQ-023 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-024 flush SHALL zero count and both pointers at the next edge, overriding any same-cycle push or pop.
REQ-025 A word matching no RV32I/WFI encoding (or RV32M when M_EXT=0) SHALL set out_illegal=1, with rd/rs1/rs2_valid, is_wfi, imm, unit and op all 0. It is still buffered and delivered.
REQ-026 With M_EXT=1, OP (0110011) with funct7=0000001 SHALL decode as unit=2'b11, op={1'b0,funct3}, imm=0, rd/rs1/rs2_valid=1, illegal=0.
REQ-027 Only WFI (0x10500073) SHALL set is_wfi; any other SYSTEM word is illegal.
REQ-028 Head fields when out_valid=0 are don't-care; the bench SHALL NOT check them.

Reset
REQ-029 reset SHALL clear count and pointers, giving out_valid=0 and in_ready=1 in the following cycle.
REQ-030 Buffer storage SHALL NOT be reset.
REQ-031 reset during simultaneous push/pop/flush SHALL take priority over all of them.

Structure
REQ-032 Package decode_pkg SHALL hold the unit/op/imm encoding constants and the packed decoded-entry struct (pc, insn, flags, imm, unit, op, illegal).
REQ-033 Combinational per-word decode SHALL live in sub-module decode_pla (parameter M_EXT), instantiated FETCH_W times.
REQ-034 An elaboration-time check SHALL reject DEPTH not a power of two, DEPTH < FETCH_W, or FETCH_W outside 1..4.

Verification
REQ-035 Reset, then in_pc=0x100, in_mask=2'b11, insn0=0x00208033 (add), insn1=0x10500073 -> in the next cycle out_pc=0x100, unit/op match add, illegal=0; after pop, out_pc=0x104 with is_wfi=1.
REQ-036 out_ready=0, repeated 2-slot bundles with DEPTH=4 -> in_ready drops after 2 accepts, count=4; one pop keeps in_ready=0 (free=1); a second pop raises it.
REQ-037 M_EXT=0 vs 1, insn 0x022081B3 (mul) -> illegal=1 with all fields 0, vs unit=2'b11, op=4'b0000, illegal=0.
REQ-038 in_mask=2'b10 -> one entry, PC = in_pc+4; mask 2'b00 -> accepted, out_valid stays 0.
REQ-039 Full buffer, flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, nothing written.
REQ-040 Random push/pop for 10^4 cycles against a scoreboard -> in-order delivery with pointer wrap, never overflow or underflow.
